single_min_arbiter: RTL
=======================

Name: single_min_arbiter

Overview:
- Round-robin arbiter that shares one pipelined single_min unit (IEEE-754 single-precision minimum) between two requesters.
- Each requester offers an (a, b) operand pair with a stb/ack handshake.
- The arbiter registers the winning pair into the shared unit and tags the operation with its requester ID. It then routes each result back to the requester that issued it, as a one-cycle strobe.
- Sits between requesting datapath blocks and a single single_min instance, so several clients do not each need their own comparator.

Parameters:
- LATENCY, 2, number of clock edges from min_a/min_b changing to the matching min_z being valid (pipeline depth of the attached single_min); legal 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_a_0  input  32  requester 0 operand a (IEEE-754 single)
- in_b_0  input  32  requester 0 operand b
- in_stb_0  input  1  requester 0 request valid
- in_ack_0  output  1  requester 0 accept (combinational)
- in_a_1  input  32  requester 1 operand a
- in_b_1  input  32  requester 1 operand b
- in_stb_1  input  1  requester 1 request valid
- in_ack_1  output  1  requester 1 accept (combinational)
- min_a  output  32  operand a to the shared single_min (registered)
- min_b  output  32  operand b to the shared single_min (registered)
- min_z  input  32  result from the shared single_min
- out_z_0  output  32  result for requester 0 (registered)
- out_stb_0  output  1  one-cycle result strobe for requester 0
- out_z_1  output  32  result for requester 1 (registered)
- out_stb_1  output  1  one-cycle result strobe for requester 1
- idle  output  1  high when no operation is issued or in flight

Behaviour:
- Reset (async, rst=1) values:
  - min_a, min_b, out_z_0, out_z_1 = 0; out_stb_0, out_stb_1 = 0.
  - Tag pipeline cleared; priority pointer = requester 0; idle = 1.
- Handshake:
  - A transfer occurs on a rising edge where in_stb_n && in_ack_n.
  - in_ack_n is never high unless in_stb_n is high.
  - At most one ack per cycle.
  - The requester holds a/b/stb stable until acked.
  - Throughput is one issue per cycle; there is no backpressure from the unit or the outputs.
- Arbitration:
  - Only one stb high: that requester is acked.
  - Both high: the requester equal to the priority pointer is acked.
  - After any transfer, the pointer moves to the requester that did not win. With no transfer, the pointer holds.
  - Consequence: two continuously requesting clients alternate 0,1,0,1...; a lone requester is acked every cycle.
- Issue: on transfer edge E, min_a/min_b capture the winner's a/b, and tag stage 0 captures {valid=1, id}. With no transfer, stage 0 captures valid=0 and min_a/min_b hold.
- Tag pipeline:
  - LATENCY+1 stages of {valid, id}, shifting every edge.
  - The last stage aligns with min_z being valid for that operation.
- Result:
  - On edge E+LATENCY+1, if the final tag is valid, out_z_id <= min_z and out_stb_id <= 1 for exactly one cycle.
  - The other requester's out_z holds and its out_stb is 0.
  - out_z_n holds its last value between strobes.
  - Overall latency is LATENCY+2 edges from the transfer edge to the end of the strobe cycle; results return in issue order.
- idle: combinational; 1 when no tag stage is valid, else 0.
- Reset mid-operation: all in-flight tags are discarded and no strobe is produced for them. The pointer returns to 0. Acks may resume on the first edge after rst deasserts.
- No arithmetic is done in the arbiter; NaN/denormal handling belongs to single_min.

Test Plan:
- Reset → all outputs 0, idle=1. Assert rst mid-stream with 2 ops in flight → no out_stb afterwards for them.
- Only stb_0, a=0x3F800000 (1.0), b=0x40000000 (2.0), LATENCY=2:
  - ack_0 same cycle.
  - out_stb_0 high exactly one cycle, LATENCY+1 edges after the transfer edge, with out_z_0=0x3F800000.
  - out_stb_1 stays 0.
- Both stb held for 6 cycles:
  - acks alternate 0,1,0,1,0,1.
  - Results strobe in the same alternating order, each on the correct port.
- Back-to-back stb_1 pairs (-1.0=0xBF800000, 1.0) then (2.0, 0x40400000=3.0):
  - out_z_1 = 0xBF800000, then 0x40000000, on consecutive cycles.
- Pointer hold: stb_1 alone wins once, then both raise → requester 0 acked first. Idle gaps do not move the pointer.
- idle:
  - 0 from the cycle after the first transfer until all results have strobed.
  - Returns to 1 on the edge of the last strobe's capture.

Source files
------------

// File: rtl/single_min_arbiter.sv
// Round-robin arbiter sharing one pipelined single_min unit between two requesters.
// A {valid,id} tag pipeline tracks each issued operation so its result returns to the issuer.
module single_min_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_a_0,
    input  logic [31:0] in_b_0,
    input  logic        in_stb_0,
    output logic        in_ack_0,
    input  logic [31:0] in_a_1,
    input  logic [31:0] in_b_1,
    input  logic        in_stb_1,
    output logic        in_ack_1,
    output logic [31:0] min_a,
    output logic [31:0] min_b,
    input  logic [31:0] min_z,
    output logic [31:0] out_z_0,
    output logic        out_stb_0,
    output logic [31:0] out_z_1,
    output logic        out_stb_1,
    output logic        idle
);

    logic             ptr_q, ptr_d;
    logic             grant_0, grant_1;
    logic             xfer, win_id;
    logic [31:0]      min_a_q, min_a_d;
    logic [31:0]      min_b_q, min_b_d;
    logic [31:0]      out_z_0_q, out_z_1_q;
    logic             out_stb_0_q, out_stb_1_q;
    logic [LATENCY:0] tag_v_q, tag_v_d;
    logic [LATENCY:0] tag_id_q, tag_id_d;
    logic             done_v, done_id;

    // Acks are suppressed while in reset so no request is consumed by a discarded edge.
    always_comb begin
        grant_0 = !rst && in_stb_0 && (!in_stb_1 || !ptr_q);
        grant_1 = !rst && in_stb_1 && (!in_stb_0 || ptr_q);
        xfer    = grant_0 || grant_1;
        win_id  = grant_1;
        ptr_d   = xfer ? !win_id : ptr_q;
        min_a_d = min_a_q;
        min_b_d = min_b_q;
        if (grant_0) begin
            min_a_d = in_a_0;
            min_b_d = in_b_0;
        end else if (grant_1) begin
            min_a_d = in_a_1;
            min_b_d = in_b_1;
        end
        tag_v_d     = tag_v_q << 1;
        tag_v_d[0]  = xfer;
        tag_id_d    = tag_id_q << 1;
        tag_id_d[0] = win_id;
    end

    assign done_v  = tag_v_q[LATENCY];
    assign done_id = tag_id_q[LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= 1'b0;
            min_a_q     <= '0;
            min_b_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            out_z_0_q   <= '0;
            out_z_1_q   <= '0;
            out_stb_0_q <= 1'b0;
            out_stb_1_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            min_a_q     <= min_a_d;
            min_b_q     <= min_b_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            out_stb_0_q <= done_v && !done_id;
            out_stb_1_q <= done_v && done_id;
            if (done_v && !done_id) out_z_0_q <= min_z;
            if (done_v && done_id)  out_z_1_q <= min_z;
        end
    end

    assign in_ack_0  = grant_0;
    assign in_ack_1  = grant_1;
    assign min_a     = min_a_q;
    assign min_b     = min_b_q;
    assign out_z_0   = out_z_0_q;
    assign out_z_1   = out_z_1_q;
    assign out_stb_0 = out_stb_0_q;
    assign out_stb_1 = out_stb_1_q;
    assign idle      = ~|tag_v_q;

endmodule
